armleocpu_cache_arbiter: RTL and testbench

Shares one armleocpu_cache command port between two requesters: port 0 (fetch, usually EXECUTE) and port 1 (load/store unit, any command). The block sits between the pipeline and the cache. It owns grant sequencing, holds the granted command stable until the cache completes it, and routes the response and load data back. Arbitration is fixed-priority to port 1, with a bounded-starvation counter that protects port 0.

---
 rtl/armleocpu_cache_arbiter_if.sv | 20 ++
 rtl/armleocpu_cache_arbiter.sv | 113 +++++++++++
 tb/tb_armleocpu_cache_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/armleocpu_cache_arbiter_if.sv
// rtl/armleocpu_cache_arbiter_if.sv - armleocpu_cache command/response port bundle
interface armleocpu_cache_arbiter_if;
  logic [3:0]  cmd;
  logic [31:0] address;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] store_data;
  logic [3:0]  response;
  logic [31:0] load_data;

  modport master (
    output cmd, address, load_type, store_type, store_data,
    input  response, load_data
  );

  modport slave (
    input  cmd, address, load_type, store_type, store_data,
    output response, load_data
  );
endinterface

// File: rtl/armleocpu_cache_arbiter.sv
// rtl/armleocpu_cache_arbiter.sv - two-requester arbiter in front of armleocpu_cache
// Port 1 has fixed priority; port 0 is guaranteed a grant after MAX_CONSEC port-1 grants.
module armleocpu_cache_arbiter #(
  parameter int MAX_CONSEC = 4,
  parameter int PRIO_CNT_W = 4
) (
  input logic                      clk,
  input logic                      rst,
  armleocpu_cache_arbiter_if.slave r0,
  armleocpu_cache_arbiter_if.slave r1,
  armleocpu_cache_arbiter_if.master c
);

  localparam logic [3:0] CMD_NONE  = 4'd0;
  localparam logic [3:0] RESP_WAIT = 4'd0;
  localparam logic [PRIO_CNT_W-1:0] CNT_MAX = PRIO_CNT_W'(MAX_CONSEC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic                  grant, grant_nxt;
  logic [PRIO_CNT_W-1:0] consec_cnt, consec_nxt;
  logic                  r0_req, r1_req;
  logic                  sel_valid, sel, complete;

  always_comb begin
    r0_req    = (r0.cmd != CMD_NONE);
    r1_req    = (r1.cmd != CMD_NONE);
    sel_valid = 1'b0;
    sel       = grant;

    // rst gates the selection so c_cmd drops to NONE without waiting for an edge
    if (!rst) begin
      if (state == BUSY) begin
        sel_valid = 1'b1;
        sel       = grant;
      end else if (r0_req || r1_req) begin
        sel_valid = 1'b1;
        sel       = r1_req && !(r0_req && (consec_cnt == CNT_MAX));
      end
    end

    complete = sel_valid && (c.response != RESP_WAIT);

    c.cmd        = CMD_NONE;
    c.address    = '0;
    c.load_type  = '0;
    c.store_type = '0;
    c.store_data = '0;
    r0.response  = RESP_WAIT;
    r0.load_data = '0;
    r1.response  = RESP_WAIT;
    r1.load_data = '0;

    if (sel_valid) begin
      if (sel) begin
        c.cmd        = r1.cmd;
        c.address    = r1.address;
        c.load_type  = r1.load_type;
        c.store_type = r1.store_type;
        c.store_data = r1.store_data;
        r1.response  = c.response;
        r1.load_data = c.load_data;
      end else begin
        c.cmd        = r0.cmd;
        c.address    = r0.address;
        c.load_type  = r0.load_type;
        c.store_type = r0.store_type;
        c.store_data = r0.store_data;
        r0.response  = c.response;
        r0.load_data = c.load_data;
      end
    end

    state_nxt  = state;
    grant_nxt  = grant;
    consec_nxt = consec_cnt;

    case (state)
      IDLE: begin
        if (sel_valid) begin
          grant_nxt = sel;
          if (!complete) state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (complete) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // streak of port-1 completions only counts while port 0 is waiting
    if (complete) begin
      if (sel && r0_req)
        consec_nxt = (consec_cnt == CNT_MAX) ? consec_cnt : consec_cnt + PRIO_CNT_W'(1);
      else
        consec_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      consec_cnt <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      consec_cnt <= consec_nxt;
    end
  end

endmodule

// File: tb/tb_armleocpu_cache_arbiter.sv
// tb/tb_armleocpu_cache_arbiter.sv - randomized transaction-level check of armleocpu_cache_arbiter
module tb_armleocpu_cache_arbiter;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  armleocpu_cache_arbiter_if r0_if ();
  armleocpu_cache_arbiter_if r1_if ();
  armleocpu_cache_arbiter_if c_if ();

  armleocpu_cache_arbiter #(.MAX_CONSEC(MAX), .PRIO_CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .r0  (r0_if),
    .r1  (r1_if),
    .c   (c_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // requester view: one outstanding command per port
  logic        act [2];
  logic [3:0]  cmd [2];
  logic [31:0] addr [2];
  logic [31:0] sd [2];
  logic [2:0]  lt [2];
  logic [1:0]  st [2];

  // transaction-level reference: who owns the cache, how long it takes, port-1 streak
  int          cur = -1;
  int          lat_left = 0;
  int          streak = 0;
  int          fix_lat = -1;
  logic [3:0]  resp;
  logic [31:0] rdata;
  int          glog[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int p, input logic [3:0] k);
    act[p]  = 1'b1;
    cmd[p]  = k;
    addr[p] = $urandom;
    lt[p]   = 3'($urandom_range(0, 7));
    st[p]   = 2'($urandom_range(0, 3));
    sd[p]   = $urandom;
  endtask

  task automatic apply();
    r0_if.cmd        = act[0] ? cmd[0] : 4'd0;
    r0_if.address    = addr[0];
    r0_if.load_type  = lt[0];
    r0_if.store_type = st[0];
    r0_if.store_data = sd[0];
    r1_if.cmd        = act[1] ? cmd[1] : 4'd0;
    r1_if.address    = addr[1];
    r1_if.load_type  = lt[1];
    r1_if.store_type = st[1];
    r1_if.store_data = sd[1];
  endtask

  task automatic compare();
    logic [3:0]  e_resp [2];
    logic [31:0] e_data [2];
    e_resp[0] = 4'd0; e_resp[1] = 4'd0;
    e_data[0] = '0;   e_data[1] = '0;
    if (cur >= 0) begin
      check("c_cmd", c_if.cmd, cmd[cur]);
      check("c_address", c_if.address, addr[cur]);
      check("c_store_data", c_if.store_data, sd[cur]);
      check("c_load_type", c_if.load_type, lt[cur]);
      check("c_store_type", c_if.store_type, st[cur]);
      e_resp[cur] = resp;
      e_data[cur] = rdata;
    end else begin
      check("idle_c_cmd", c_if.cmd, 0);
      check("idle_c_address", c_if.address, 0);
      check("idle_c_store_data", c_if.store_data, 0);
    end
    check("r0_response", r0_if.response, e_resp[0]);
    check("r0_load_data", r0_if.load_data, e_data[0]);
    check("r1_response", r1_if.response, e_resp[1]);
    check("r1_load_data", r1_if.load_data, e_data[1]);
  endtask

  // one clock cycle: called at posedge+1, returns at the next posedge+1
  task automatic step(input bit allow_new);
    apply();
    if (cur < 0) begin
      if (act[0] && act[1]) cur = (streak == MAX) ? 0 : 1;
      else if (act[1])      cur = 1;
      else if (act[0])      cur = 0;
      if (cur >= 0) lat_left = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
    end
    resp  = (cur >= 0 && lat_left == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
    rdata = $urandom;
    c_if.response  = resp;
    c_if.load_data = rdata;
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    if (cur >= 0) begin
      if (resp != 4'd0) begin
        if (cur == 1 && act[0]) streak = (streak < MAX) ? streak + 1 : MAX;
        else                    streak = 0;
        glog.push_back(cur);
        act[cur] = 1'b0;
        cur = -1;
      end else begin
        lat_left--;
      end
    end
    if (allow_new) begin
      for (int p = 0; p < 2; p++)
        if (!act[p] && $urandom_range(0, 3) != 0) new_req(p, 4'($urandom_range(1, 6)));
    end
  endtask

  task automatic run_until(input string tag, input int n, input int bound);
    int k = 0;
    while (glog.size() < n && k < bound) begin
      step(1'b0);
      k++;
    end
    check(tag, glog.size() >= n, 1);
  endtask

  initial begin
    int exp_ord [7] = '{1, 1, 1, 1, 0, 1, 1};
    int r1_left;
    int n0;

    act[0] = 1'b0; act[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cmd[p] = 4'd0; addr[p] = '0; sd[p] = '0; lt[p] = '0; st[p] = '0;
    end
    apply();
    c_if.response  = 4'd0;
    c_if.load_data = '0;

    // reset state with no requests
    repeat (2) @(negedge clk);
    check("rst_c_cmd", c_if.cmd, 0);
    check("rst_c_address", c_if.address, 0);
    check("rst_r0_response", r0_if.response, 0);
    check("rst_r1_response", r1_if.response, 0);
    check("rst_r0_load_data", r0_if.load_data, 0);

    // request during reset stays blocked
    new_req(0, 4'd1);
    addr[0] = 32'h100;
    apply();
    c_if.response = 4'd1;
    #1;
    check("rst_gate_c_cmd", c_if.cmd, 0);
    check("rst_gate_r0_response", r0_if.response, 0);
    c_if.response = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // r0 EXECUTE 0x100, three WAIT cycles
    fix_lat = 3;
    run_until("exec_done", 1, 20);
    check("exec_grant", glog[0], 0);

    // starvation bound: r0 held, r1 issues 6 back-to-back
    glog.delete();
    fix_lat = 0;
    new_req(0, 4'd2); addr[0] = 32'h0;
    new_req(1, 4'd3); addr[1] = 32'h40; sd[1] = 32'hFF00FF00;
    r1_left = 5;
    for (int k = 0; k < 30 && glog.size() < 7; k++) begin
      step(1'b0);
      if (!act[1] && r1_left > 0) begin
        new_req(1, 4'd2);
        r1_left--;
      end
    end
    check("starve_count", glog.size(), 7);
    for (int i = 0; i < 7 && i < glog.size(); i++)
      check($sformatf("starve_order_%0d", i), glog[i], exp_ord[i]);

    // r0 FLUSH_ALL arrives while r1 LOAD is in flight
    glog.delete();
    fix_lat = 3;
    new_req(1, 4'd2);
    step(1'b0);
    new_req(0, 4'd4);
    run_until("flush_done", 2, 30);
    if (glog.size() >= 2) begin
      check("flush_first", glog[0], 1);
      check("flush_second", glog[1], 0);
    end

    // reset pulsed while r1 is BUSY
    glog.delete();
    fix_lat = 10;
    new_req(1, 4'd2);
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
    c_if.response = 4'd1;
    #1;
    check("midrst_c_cmd", c_if.cmd, 0);
    check("midrst_r1_response", r1_if.response, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    c_if.response = 4'd0;
    cur = -1;
    streak = 0;
    fix_lat = 1;
    n0 = glog.size();
    run_until("midrst_regrant", n0 + 1, 20);
    if (glog.size() > n0) check("midrst_port", glog[n0], 1);

    // randomized traffic
    glog.delete();
    fix_lat = -1;
    for (int k = 0; k < 1500; k++) step(1'b1);
    check("random_progress", glog.size() > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
